// File: rtl/mem_operand_fetcher.sv
`timescale 1ns/1ps
// mem_operand_fetcher: latches NUM_OPS operands, fetching masked ones from memory.
// Optional misaligned-pointer check enabled by defining MEMOP_ALIGN_CHECK_EN.

module mem_operand_fetcher #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int NUM_OPS = 2,
   parameter int MEM_LAT = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [NUM_OPS-1:0]        ind_mask,
   input  logic [NUM_OPS*ADDR_W-1:0] src_in,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic                      mem_rd,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [NUM_OPS*DATA_W-1:0] op_out
);

   localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
   localparam int CNT_W = $clog2(MEM_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_DONE
   } state_t;

   state_t                    state;
   state_t                    nxt;
   logic [NUM_OPS*ADDR_W-1:0] ptr_q;
   logic [NUM_OPS-1:0]        mask_q;
   logic [IDX_W-1:0]          idx;
   logic [CNT_W-1:0]          cnt;

   int                        scan_base;
   logic [NUM_OPS*ADDR_W-1:0] scan_src;
   logic [NUM_OPS-1:0]        scan_mask;
   logic                      scan_go;
   logic                      hit;
   logic [IDX_W-1:0]          hit_idx;
`ifdef MEMOP_ALIGN_CHECK_EN
   logic [NUM_OPS-1:0]        skip;
`endif

   // Zero-cycle scan: next fetched channel at or above the scan base
   always_comb begin
      scan_base = (state == S_IDLE) ? 0 : int'(idx) + 1;
      scan_src  = (state == S_IDLE) ? src_in : ptr_q;
      scan_mask = (state == S_IDLE) ? ind_mask : mask_q;
      scan_go   = (state == S_IDLE && start) || (state == S_CAPTURE);
      hit       = 1'b0;
      hit_idx   = '0;
`ifdef MEMOP_ALIGN_CHECK_EN
      skip      = '0;
`endif
      for (int j = 0; j < NUM_OPS; j++) begin
         if (!hit && j >= scan_base && scan_mask[j]) begin
`ifdef MEMOP_ALIGN_CHECK_EN
            if (scan_src[j*ADDR_W +: 2] != 2'b00) begin
               skip[j] = 1'b1;
            end else begin
               hit     = 1'b1;
               hit_idx = j[IDX_W-1:0];
            end
`else
            hit     = 1'b1;
            hit_idx = j[IDX_W-1:0];
`endif
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= nxt;
   end

   // Next-state and strobes
   always_comb begin
      nxt    = state;
      mem_rd = 1'b0;
      busy   = 1'b1;
      done   = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) nxt = hit ? S_ISSUE : S_DONE;
         end
         S_ISSUE: begin
            mem_rd = 1'b1;
            nxt    = (MEM_LAT > 1) ? S_WAIT : S_CAPTURE;
         end
         S_WAIT: begin
            if (cnt == CNT_W'(1)) nxt = S_CAPTURE;
         end
         S_CAPTURE: nxt = hit ? S_ISSUE : S_DONE;
         S_DONE: begin
            done = 1'b1;
            nxt  = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Operand, pointer, address and wait-counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q    <= '0;
         mask_q   <= '0;
         idx      <= '0;
         cnt      <= '0;
         mem_addr <= '0;
         op_out   <= '0;
`ifdef MEMOP_ALIGN_CHECK_EN
         err      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  ptr_q  <= src_in;
                  mask_q <= ind_mask;
                  for (int i = 0; i < NUM_OPS; i++) begin
                     if (!ind_mask[i])
                        op_out[i*DATA_W +: DATA_W] <=
                           DATA_W'(src_in[i*ADDR_W +: ADDR_W]);
                  end
`ifdef MEMOP_ALIGN_CHECK_EN
                  err <= |skip;
`endif
               end
            end
            S_ISSUE: cnt <= CNT_W'(MEM_LAT - 1);
            S_WAIT:  cnt <= cnt - 1'b1;
            S_CAPTURE: begin
               op_out[idx*DATA_W +: DATA_W] <= mem_rdata;
`ifdef MEMOP_ALIGN_CHECK_EN
               err <= err | (|skip);
`endif
            end
            default: ;
         endcase
         if (scan_go && hit) begin
            idx      <= hit_idx;
            mem_addr <= scan_src[hit_idx*ADDR_W +: ADDR_W];
         end
`ifdef MEMOP_ALIGN_CHECK_EN
         if (scan_go) begin
            for (int i = 0; i < NUM_OPS; i++) begin
               if (skip[i]) op_out[i*DATA_W +: DATA_W] <= '0;
            end
         end
`endif
      end
   end

`ifndef MEMOP_ALIGN_CHECK_EN
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_operand_fetcher.sv
`timescale 1ns/1ps
// tb_mem_operand_fetcher: scoreboard bench for two fetcher configurations.
// dut0: NUM_OPS=2/MEM_LAT=1, dut1: NUM_OPS=4/MEM_LAT=3.

module tb_mem_operand_fetcher;

   localparam int NO0 = 2;
   localparam int LT0 = 1;
   localparam int NO1 = 4;
   localparam int LT1 = 3;
`ifdef MEMOP_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;

   logic         st0 = 1'b0, st1 = 1'b0;
   logic [1:0]   mk0 = '0;
   logic [3:0]   mk1 = '0;
   logic [63:0]  sr0 = '0;
   logic [127:0] sr1 = '0;
   logic [31:0]  md0, md1;
   logic [31:0]  a0, a1;
   logic         r0, r1, b0, b1, d0, d1, e0, e1;
   logic [63:0]  o0;
   logic [127:0] o1;

   mem_operand_fetcher #(
      .DATA_W(32), .ADDR_W(32), .NUM_OPS(NO0), .MEM_LAT(LT0)
   ) u_dut0 (
      .clk(clk), .reset(reset), .start(st0), .ind_mask(mk0),
      .src_in(sr0), .mem_rdata(md0), .mem_addr(a0), .mem_rd(r0),
      .busy(b0), .done(d0), .err(e0), .op_out(o0)
   );

   mem_operand_fetcher #(
      .DATA_W(32), .ADDR_W(32), .NUM_OPS(NO1), .MEM_LAT(LT1)
   ) u_dut1 (
      .clk(clk), .reset(reset), .start(st1), .ind_mask(mk1),
      .src_in(sr1), .mem_rdata(md1), .mem_addr(a1), .mem_rd(r1),
      .busy(b1), .done(d1), .err(e1), .op_out(o1)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents: a few fixed words, a hash everywhere else
   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h10) return 32'h64;
      if (a == 32'h20) return 32'h7;
      if (a == 32'h40) return 32'h5;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // Read data appears MEM_LAT cycles after the issue cycle; junk otherwise
   logic [31:0] p0;
   logic [31:0] p1 [3];
   always @(posedge clk) begin
      p0    <= r0 ? memf(a0) : $urandom;
      p1[0] <= r1 ? memf(a1) : $urandom;
      p1[1] <= p1[0];
      p1[2] <= p1[1];
   end
   assign md0 = p0;
   assign md1 = p1[2];

   logic [31:0]  addr_v [2];
   logic         rd_v [2], busy_v [2], done_v [2], err_v [2];
   logic [127:0] op_v [2];
   assign addr_v[0] = a0;  assign addr_v[1] = a1;
   assign rd_v[0]   = r0;  assign rd_v[1]   = r1;
   assign busy_v[0] = b0;  assign busy_v[1] = b1;
   assign done_v[0] = d0;  assign done_v[1] = d1;
   assign err_v[0]  = e0;  assign err_v[1]  = e1;
   assign op_v[0]   = {64'h0, o0};
   assign op_v[1]   = o1;

   typedef struct {
      int          dut;
      int          cyc;
      logic [31:0] addr;
   } rd_exp_t;

   typedef struct {
      int           dut;
      int           cyc;
      logic [127:0] op;
      logic         err;
   } done_exp_t;

   rd_exp_t   rq [$];
   done_exp_t dq [$];

   int           t0 [2];
   int           tend [2];
   logic [127:0] old_op [2], new_op [2];
   logic         old_err [2], new_err [2];
   logic [31:0]  last_addr [2];
   logic [3:0]   cur_mask [2];

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input int d,
                        input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h",
                  nm, d, cyc, act, exp);
      end
   endtask

   function automatic int find_rq(input int d);
      for (int k = 0; k < rq.size(); k++)
         if (rq[k].dut == d) return k;
      return -1;
   endfunction

   function automatic int find_dq(input int d);
      for (int k = 0; k < dq.size(); k++)
         if (dq[k].dut == d) return k;
      return -1;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         t0[d] = 1; tend[d] = 0;
         old_op[d] = '0; new_op[d] = '0;
         old_err[d] = 1'b0; new_err[d] = 1'b0;
         last_addr[d] = '0; cur_mask[d] = '0;
      end
      rq.delete();
      dq.delete();
   endtask

   task automatic drive(input int d, input logic st,
                        input logic [3:0] m, input logic [127:0] s);
      if (d == 0) begin
         st0 = st; mk0 = m[1:0]; sr0 = s[63:0];
      end else begin
         st1 = st; mk1 = m; sr1 = s;
      end
   endtask

   // Monitor: compares every cycle against the scoreboard queues and model
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int   qi;
         int   nops;
         bit   exp_b;
         bit   exp_e;
         nops  = (d == 0) ? NO0 : NO1;
         exp_b = (cyc >= t0[d]) && (cyc <= tend[d]);
         check("busy", d, 128'(busy_v[d]), 128'(exp_b));

         qi = find_rq(d);
         if (qi >= 0 && rq[qi].cyc < cyc) begin
            rq.delete(qi);
            qi = find_rq(d);
         end
         exp_e = (qi >= 0) && (rq[qi].cyc == cyc);
         check("mem_rd", d, 128'(rd_v[d]), 128'(exp_e));
         if (exp_e) begin
            check("mem_addr_issue", d, 128'(addr_v[d]), 128'(rq[qi].addr));
            last_addr[d] = rq[qi].addr;
            rq.delete(qi);
         end else begin
            check("mem_addr_hold", d, 128'(addr_v[d]), 128'(last_addr[d]));
         end

         qi = find_dq(d);
         if (qi >= 0 && dq[qi].cyc < cyc) begin
            dq.delete(qi);
            qi = find_dq(d);
         end
         exp_e = (qi >= 0) && (dq[qi].cyc == cyc);
         check("done", d, 128'(done_v[d]), 128'(exp_e));
         if (exp_e) begin
            check("op_done", d, op_v[d], dq[qi].op);
            check("err_done", d, 128'(err_v[d]), 128'(dq[qi].err));
            dq.delete(qi);
         end

         if (!exp_b) begin
            check("op_idle", d, op_v[d],
                  (cyc < t0[d]) ? old_op[d] : new_op[d]);
            check("err_idle", d, 128'(err_v[d]),
                  128'((cyc < t0[d]) ? old_err[d] : new_err[d]));
         end else begin
            for (int i = 0; i < nops; i++)
               if (!cur_mask[d][i])
                  check("op_pass", d, 128'(op_v[d][i*32 +: 32]),
                        128'(new_op[d][i*32 +: 32]));
         end
      end
   end

   task automatic assert_reset();
      reset = 1'b0;
      drive(0, 1'b0, '0, '0);
      drive(1, 1'b0, '0, '0);
      model_clear();
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_addr", d, 128'(addr_v[d]), 128'(0));
         check("rst_rd", d, 128'(rd_v[d]), 128'(0));
         check("rst_busy", d, 128'(busy_v[d]), 128'(0));
         check("rst_done", d, 128'(done_v[d]), 128'(0));
         check("rst_err", d, 128'(err_v[d]), 128'(0));
         check("rst_op", d, op_v[d], 128'(0));
      end
   endtask

   // Issue one accepted start and run until the expected done cycle
   task automatic issue(input int d, input logic [3:0] m,
                        input logic [127:0] s, input bit noise,
                        input int abort_at);
      int           nops, lat, k, g, n;
      logic [127:0] op;
      logic         er;
      logic [31:0]  p;
      nops = (d == 0) ? NO0 : NO1;
      lat  = (d == 0) ? LT0 : LT1;
      g = 0;
      while (cyc <= tend[d] && g < 2000) begin
         @(posedge clk); #2; g++;
      end
      op = new_op[d];
      er = 1'b0;
      k  = 0;
      for (int i = 0; i < nops; i++) begin
         p = s[i*32 +: 32];
         if (!m[i]) begin
            op[i*32 +: 32] = p;
         end else if (ALIGN && p[1:0] != 2'b00) begin
            op[i*32 +: 32] = '0;
            er = 1'b1;
         end else begin
            op[i*32 +: 32] = memf(p);
            rq.push_back('{dut: d, cyc: cyc + 1 + k*(lat+1), addr: p});
            k++;
         end
      end
      t0[d]      = cyc + 1;
      tend[d]    = cyc + 1 + k*(lat+1);
      old_op[d]  = new_op[d];
      new_op[d]  = op;
      old_err[d] = new_err[d];
      new_err[d] = er;
      cur_mask[d] = m;
      dq.push_back('{dut: d, cyc: tend[d], op: op, err: er});
      drive(d, 1'b1, m, s);
      @(posedge clk); #2;
      g = 0;
      while (cyc <= tend[d] && g < 2000) begin
         n = cyc - t0[d] + 1;
         if (abort_at == n) begin
            #1;
            assert_reset();
            return;
         end
         drive(d, (n == 2) || (n == 9) ||
                  (noise && $urandom_range(3) == 0),
               4'($urandom), {$urandom, $urandom, $urandom, $urandom});
         @(posedge clk); #2; g++;
      end
      drive(d, 1'b0, 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
   endtask

   initial begin
      logic [127:0] s;
      logic [3:0]   m;
      int           d;
      model_clear();
      repeat (3) @(posedge clk);
      #2;
      assert_reset();
      @(posedge clk); #2;
      reset = 1'b1;
      repeat (10) @(posedge clk);
      #2;

      issue(0, 4'b0011, {64'h0, 32'h20, 32'h10}, 1'b0, 0);
      issue(0, 4'b0001, {64'h0, 32'hDEAD_BEEF, 32'h40}, 1'b0, 0);
      issue(0, 4'b0000, {64'h0, 32'h1234_5678, 32'h9ABC_DEF0}, 1'b1, 0);
      issue(1, 4'b1111,
            {32'h4000, 32'h3000, 32'h2000, 32'h1000}, 1'b0, 0);

      issue(0, 4'b0011, {64'h0, 32'h20, 32'h10}, 1'b0, 2);
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      issue(0, 4'b0011, {64'h0, 32'h20, 32'h10}, 1'b0, 0);

      issue(0, 4'b0011, {64'h0, 32'h20, 32'h12}, 1'b0, 0);
      issue(0, 4'b0011, {64'h0, 32'h20, 32'h10}, 1'b0, 0);

      for (int t = 0; t < 24; t++) begin
         d = int'($urandom_range(1));
         m = 4'($urandom);
         s = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(1) == 0)
            for (int i = 0; i < 4; i++) s[i*32 +: 2] = 2'b00;
         issue(d, m, s, 1'b1, 0);
      end

      repeat (6) @(posedge clk);
      #2;
      check("rq_empty", 0, 128'(rq.size()), 128'(0));
      check("dq_empty", 0, 128'(dq.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
